// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types, constants and helpers for the instruction-fetch unit
//   ifu_state_t          fetch FSM state encoding
//   INSN_W               instruction width
//   IFU_RESET_PC_DEFAULT default PC after reset
//   is_misaligned()      flags a PC that is not word aligned
package ifu_pkg;
    localparam int INSN_W = 32;
    localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h8000_0000;
    typedef enum logic [2:0] {
        FETCH_REQ,
        FETCH_WAIT,
        SEND,
        WAIT_PC,
        HALT
    } ifu_state_t;
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: memory req/rsp port plus the idu-facing send/pc-redirect handshake
//   master: the fetch unit (drives req and send sides)
//   slave : the environment (memory and idu)
interface ifu_fetch_if;
    import ifu_pkg::*;
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [31:0]       ifu_req_addr;
    logic              ifu_rsp_valid;
    logic [INSN_W-1:0] ifu_rsp_data;
    logic              ifu_send_valid;
    logic              ifu_receive_ready;
    logic [INSN_W-1:0] instruction;
    logic [31:0]       pc;
    logic [31:0]       pc_next;
    logic              pc_write_enable;
    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_send_valid, instruction, pc,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_receive_ready, pc_next, pc_write_enable
    );
    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_send_valid, instruction, pc,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_receive_ready, pc_next, pc_write_enable
    );
endinterface

// File: rtl/ifu_timeout_cnt.sv
// ifu_timeout_cnt: counts cycles spent waiting for a fetch response
//   clk, rst   clock, asynchronous active-low reset
//   clear      zero the counter (held while a request is outstanding-to-be)
//   enable     count this cycle
//   expire     high in the last allowed wait cycle (count == TIMEOUT_CYCLES-1); never when TIMEOUT_CYCLES==0
module ifu_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign expire = (TIMEOUT_CYCLES != 0) && enable && (cnt_q == LAST);
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-issue instruction fetch stage feeding idu
//   clk, rst     clock, asynchronous active-low reset
//   bus          ifu_fetch_if.master: memory req/rsp, send toward idu, pc redirect from idu
//   fetch_error  sticky: misaligned PC load or fetch timeout (FSM parks in HALT)
//   fetch_count  instructions handed to idu, wraps mod 2**32
module ifu_fetch import ifu_pkg::*; #(
    parameter logic [31:0] RESET_PC       = IFU_RESET_PC_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          CNT_W          = 9
) (
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  bus,
    output logic         fetch_error,
    output logic [31:0]  fetch_count
);
    ifu_state_t        state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [INSN_W-1:0] insn_q, insn_d;
    logic              req_valid_q, req_valid_d;
    logic              send_valid_q, send_valid_d;
    logic              error_q, error_d;
    logic [31:0]       count_q, count_d;
    logic              pending_q, pending_d;
    logic [31:0]       next_pc_q, next_pc_d;
    logic              req_fire, send_fire, expire;
    logic [31:0]       load_pc;
    assign req_fire  = req_valid_q && bus.ifu_req_ready;
    assign send_fire = send_valid_q && bus.ifu_receive_ready;
    // a live strobe is newer than anything latched earlier
    assign load_pc   = bus.pc_write_enable ? bus.pc_next : next_pc_q;
    ifu_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == FETCH_REQ),
        .enable (state_q == FETCH_WAIT),
        .expire (expire)
    );
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        req_valid_d  = req_valid_q;
        send_valid_d = send_valid_q;
        error_d      = error_q;
        count_d      = count_q;
        pending_d    = pending_q;
        next_pc_d    = next_pc_q;
        // idu may resolve the next PC before we reach WAIT_PC; park it until then
        if (bus.pc_write_enable && state_q != WAIT_PC) begin
            next_pc_d = bus.pc_next;
            pending_d = 1'b1;
        end
        case (state_q)
            FETCH_REQ: begin
                req_valid_d = !req_fire;
                if (req_fire) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                // response beats timeout when both land in the same cycle
                if (bus.ifu_rsp_valid) begin
                    insn_d       = bus.ifu_rsp_data;
                    send_valid_d = 1'b1;
                    state_d      = SEND;
                end else if (expire) begin
                    error_d = 1'b1;
                    state_d = HALT;
                end
            end
            SEND: begin
                if (send_fire) begin
                    send_valid_d = 1'b0;
                    count_d      = count_q + 32'd1;
                    state_d      = WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (bus.pc_write_enable || pending_q) begin
                    pc_d      = load_pc;
                    pending_d = 1'b0;
                    if (is_misaligned(load_pc)) begin
                        error_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        req_valid_d = 1'b1;
                        state_d     = FETCH_REQ;
                    end
                end
            end
            HALT: begin
                req_valid_d  = 1'b0;
                send_valid_d = 1'b0;
                error_d      = 1'b1;
            end
            default: begin
                error_d = 1'b1;
                state_d = HALT;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH_REQ;
            pc_q         <= RESET_PC;
            insn_q       <= '0;
            req_valid_q  <= 1'b0;
            send_valid_q <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
            pending_q    <= 1'b0;
            next_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            req_valid_q  <= req_valid_d;
            send_valid_q <= send_valid_d;
            error_q      <= error_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            next_pc_q    <= next_pc_d;
        end
    end
    assign bus.ifu_req_valid  = req_valid_q;
    assign bus.ifu_req_addr   = pc_q;
    assign bus.ifu_send_valid = send_valid_q;
    assign bus.instruction    = insn_q;
    assign bus.pc             = pc_q;
    assign fetch_error        = error_q;
    assign fetch_count        = count_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios for ifu_fetch with hand-computed expectations
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_error;
    logic [31:0] fetch_count;
    int          errors = 0;
    int          checks = 0;

    ifu_fetch_if bus();

    ifu_fetch #(
        .RESET_PC       (32'h8000_0000),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .fetch_error (fetch_error),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.ifu_req_ready     = 1'b0;
        bus.ifu_rsp_valid     = 1'b0;
        bus.ifu_rsp_data      = '0;
        bus.ifu_receive_ready = 1'b0;
        bus.pc_next           = '0;
        bus.pc_write_enable   = 1'b0;
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0b exp=0", bus.ifu_req_valid); end
        checks++; if (bus.ifu_send_valid !== 1'b0) begin errors++; $display("FAIL reset_send_valid got=%0b exp=0", bus.ifu_send_valid); end
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", fetch_error); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        checks++; if (bus.pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got=%h exp=80000000", bus.pc); end
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL reset_insn got=%h exp=00000000", bus.instruction); end
        rst = 1'b1;
        #1;
        checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL release_req_valid got=%0b exp=0", bus.ifu_req_valid); end
        tick();
        checks++; if (bus.ifu_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got=%0b exp=1", bus.ifu_req_valid); end
        checks++; if (bus.ifu_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL first_req_addr got=%h exp=80000000", bus.ifu_req_addr); end
    endtask

    task automatic test_basic;
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL basic_req_drop got=%0b exp=0", bus.ifu_req_valid); end
        bus.ifu_rsp_valid     = 1'b1;
        bus.ifu_rsp_data      = 32'h0000_0413;
        bus.ifu_receive_ready = 1'b1;
        tick();
        bus.ifu_rsp_valid = 1'b0;
        checks++; if (bus.ifu_send_valid !== 1'b1) begin errors++; $display("FAIL basic_send_valid got=%0b exp=1", bus.ifu_send_valid); end
        checks++; if (bus.instruction !== 32'h0000_0413) begin errors++; $display("FAIL basic_insn got=%h exp=00000413", bus.instruction); end
        checks++; if (bus.pc !== 32'h8000_0000) begin errors++; $display("FAIL basic_pc got=%h exp=80000000", bus.pc); end
        tick();
        checks++; if (bus.ifu_send_valid !== 1'b0) begin errors++; $display("FAIL basic_send_drop got=%0b exp=0", bus.ifu_send_valid); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", fetch_count); end
        checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL basic_waitpc_req got=%0b exp=0", bus.ifu_req_valid); end
        bus.pc_write_enable = 1'b1;
        bus.pc_next         = 32'h8000_0004;
        tick();
        bus.pc_write_enable = 1'b0;
        checks++; if (bus.ifu_req_valid !== 1'b1) begin errors++; $display("FAIL basic_next_req got=%0b exp=1", bus.ifu_req_valid); end
        checks++; if (bus.ifu_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL basic_next_addr got=%h exp=80000004", bus.ifu_req_addr); end
    endtask

    task automatic test_backpressure;
        bus.ifu_receive_ready = 1'b0;
        bus.ifu_req_ready     = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = 32'h0010_0093;
        tick();
        bus.ifu_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.ifu_send_valid !== 1'b1) begin errors++; $display("FAIL bp_send_valid[%0d] got=%0b exp=1", i, bus.ifu_send_valid); end
            checks++; if (bus.instruction !== 32'h0010_0093) begin errors++; $display("FAIL bp_insn[%0d] got=%h exp=00100093", i, bus.instruction); end
            checks++; if (bus.pc !== 32'h8000_0004) begin errors++; $display("FAIL bp_pc[%0d] got=%h exp=80000004", i, bus.pc); end
            checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL bp_count[%0d] got=%0d exp=1", i, fetch_count); end
            tick();
        end
        bus.ifu_receive_ready = 1'b1;
        tick();
        checks++; if (bus.ifu_send_valid !== 1'b0) begin errors++; $display("FAIL bp_send_drop got=%0b exp=0", bus.ifu_send_valid); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL bp_count_after got=%0d exp=2", fetch_count); end
        bus.pc_write_enable = 1'b1;
        bus.pc_next         = 32'h8000_0008;
        tick();
        bus.pc_write_enable = 1'b0;
        checks++; if (bus.ifu_req_addr !== 32'h8000_0008) begin errors++; $display("FAIL bp_next_addr got=%h exp=80000008", bus.ifu_req_addr); end
    endtask

    task automatic test_req_stall;
        bus.ifu_receive_ready = 1'b0;
        bus.ifu_req_ready     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.ifu_req_valid !== 1'b1) begin errors++; $display("FAIL stall_req_valid[%0d] got=%0b exp=1", i, bus.ifu_req_valid); end
            checks++; if (bus.ifu_req_addr !== 32'h8000_0008) begin errors++; $display("FAIL stall_req_addr[%0d] got=%h exp=80000008", i, bus.ifu_req_addr); end
            bus.ifu_rsp_valid = (i == 1);
            bus.ifu_rsp_data  = 32'hDEAD_BEEF;
            tick();
        end
        bus.ifu_rsp_valid = 1'b0;
        checks++; if (bus.ifu_send_valid !== 1'b0) begin errors++; $display("FAIL stall_stray_rsp_send got=%0b exp=0", bus.ifu_send_valid); end
        checks++; if (bus.instruction !== 32'h0010_0093) begin errors++; $display("FAIL stall_stray_rsp_insn got=%h exp=00100093", bus.instruction); end
        checks++; if (bus.ifu_req_valid !== 1'b1) begin errors++; $display("FAIL stall_still_req got=%0b exp=1", bus.ifu_req_valid); end
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_drop got=%0b exp=0", bus.ifu_req_valid); end
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = 32'h0020_0113;
        tick();
        bus.ifu_rsp_valid = 1'b0;
        checks++; if (bus.instruction !== 32'h0020_0113) begin errors++; $display("FAIL stall_insn got=%h exp=00200113", bus.instruction); end
    endtask

    task automatic test_pending_pc;
        bus.pc_write_enable = 1'b1;
        bus.pc_next         = 32'h8000_0200;
        tick();
        bus.pc_next = 32'h8000_0100;
        tick();
        bus.pc_write_enable = 1'b0;
        checks++; if (bus.ifu_send_valid !== 1'b1) begin errors++; $display("FAIL pend_send_held got=%0b exp=1", bus.ifu_send_valid); end
        checks++; if (bus.pc !== 32'h8000_0008) begin errors++; $display("FAIL pend_pc_held got=%h exp=80000008", bus.pc); end
        bus.ifu_receive_ready = 1'b1;
        tick();
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL pend_count got=%0d exp=3", fetch_count); end
        checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL pend_waitpc_req got=%0b exp=0", bus.ifu_req_valid); end
        tick();
        checks++; if (bus.ifu_req_valid !== 1'b1) begin errors++; $display("FAIL pend_next_req got=%0b exp=1", bus.ifu_req_valid); end
        checks++; if (bus.ifu_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL pend_next_addr got=%h exp=80000100", bus.ifu_req_addr); end
    endtask

    task automatic test_misaligned;
        bus.ifu_receive_ready = 1'b1;
        bus.ifu_req_ready     = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = 32'h0000_0013;
        tick();
        bus.ifu_rsp_valid = 1'b0;
        tick();
        bus.pc_write_enable = 1'b1;
        bus.pc_next         = 32'h8000_0102;
        tick();
        bus.pc_write_enable = 1'b0;
        checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL mis_error got=%0b exp=1", fetch_error); end
        checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL mis_req got=%0b exp=0", bus.ifu_req_valid); end
        checks++; if (bus.pc !== 32'h8000_0102) begin errors++; $display("FAIL mis_pc got=%h exp=80000102", bus.pc); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL mis_count got=%0d exp=4", fetch_count); end
        bus.ifu_req_ready = 1'b1;
        bus.ifu_rsp_valid = 1'b1;
        tick();
        tick();
        tick();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL halt_req got=%0b exp=0", bus.ifu_req_valid); end
        checks++; if (bus.ifu_send_valid !== 1'b0) begin errors++; $display("FAIL halt_send got=%0b exp=0", bus.ifu_send_valid); end
        checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL halt_sticky got=%0b exp=1", fetch_error); end
    endtask

    task automatic test_timeout;
        apply_reset();
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL to_reset_error got=%0b exp=0", fetch_error); end
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        repeat (7) tick();
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL to_early_error got=%0b exp=0", fetch_error); end
        tick();
        checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL to_error got=%0b exp=1", fetch_error); end
        bus.ifu_rsp_valid = 1'b1;
        tick();
        bus.ifu_rsp_valid = 1'b0;
        checks++; if (bus.ifu_send_valid !== 1'b0) begin errors++; $display("FAIL to_late_rsp got=%0b exp=0", bus.ifu_send_valid); end
    endtask

    task automatic test_timeout_rsp_wins;
        apply_reset();
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        repeat (7) tick();
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = 32'h0030_0193;
        tick();
        bus.ifu_rsp_valid = 1'b0;
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL race_error got=%0b exp=0", fetch_error); end
        checks++; if (bus.ifu_send_valid !== 1'b1) begin errors++; $display("FAIL race_send got=%0b exp=1", bus.ifu_send_valid); end
        checks++; if (bus.instruction !== 32'h0030_0193) begin errors++; $display("FAIL race_insn got=%h exp=00300193", bus.instruction); end
    endtask

    task automatic test_reset_mid_fetch;
        bus.ifu_receive_ready = 1'b1;
        tick();
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL mid_pre_count got=%0d exp=1", fetch_count); end
        bus.pc_write_enable = 1'b1;
        bus.pc_next         = 32'h8000_0040;
        tick();
        bus.pc_write_enable = 1'b0;
        checks++; if (bus.ifu_req_addr !== 32'h8000_0040) begin errors++; $display("FAIL mid_pre_addr got=%h exp=80000040", bus.ifu_req_addr); end
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL mid_async_count got=%0d exp=0", fetch_count); end
        checks++; if (bus.pc !== 32'h8000_0000) begin errors++; $display("FAIL mid_async_pc got=%h exp=80000000", bus.pc); end
        checks++; if (bus.ifu_send_valid !== 1'b0) begin errors++; $display("FAIL mid_async_send got=%0b exp=0", bus.ifu_send_valid); end
        tick();
        rst = 1'b1;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = 32'hCAFE_BABE;
        tick();
        checks++; if (bus.ifu_req_valid !== 1'b1) begin errors++; $display("FAIL mid_req_after got=%0b exp=1", bus.ifu_req_valid); end
        tick();
        bus.ifu_rsp_valid = 1'b0;
        checks++; if (bus.ifu_send_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_send got=%0b exp=0", bus.ifu_send_valid); end
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL mid_stale_insn got=%h exp=00000000", bus.instruction); end
        checks++; if (bus.ifu_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL mid_addr got=%h exp=80000000", bus.ifu_req_addr); end
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL mid_error got=%0b exp=0", fetch_error); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_req_stall();
        test_pending_pc();
        test_misaligned();
        test_timeout();
        test_timeout_rsp_wins();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
